kvaz_multi: RTL

KVAZ_MULTI -- requirements
Module: kvaz_multi

---
 rtl/kvaz_multi.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/kvaz_multi.sv
// kvaz_multi: bank of NUM_DISKS RAM-disk control registers sitting on CPU I/O
// ports. Each disk maps part of the CPU address space (and optionally the
// stack) onto its own group of four SDRAM pages. Control writes go into a
// shadow register and, when DEFER=1, take effect only at the next opcode
// fetch, so code that reprograms a disk keeps running from the old mapping
// until its current instruction finishes.
module kvaz_multi #(
    parameter int         NUM_DISKS = 4,
    parameter logic [7:0] PORT_BASE = 8'h10,
    parameter int         BA_W      = 5,
    parameter bit         DEFER     = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clke,
    input  logic                 port_wr,
    input  logic [7:0]           port_addr,
    input  logic [7:0]           data_in,
    input  logic [15:0]          address,
    input  logic                 stack,
    input  logic                 memrd,
    input  logic                 memwr,
    input  logic                 m1,
    output logic [BA_W-1:0]      bigram_addr,
    output logic                 blk_n,
    output logic [NUM_DISKS-1:0] pending,
    output logic [7:0]           conflict_cnt
);

    // Control register layout:
    // [1:0] ram page, [3:2] stack page, [4] stack_on, [5] ram_on,
    // [6] window 8000-9FFF enable, [7] window E000-FFFF enable.
    logic [7:0]           shadow    [NUM_DISKS];
    logic [7:0]           committed [NUM_DISKS];
    logic [NUM_DISKS-1:0] pending_r;
    logic [NUM_DISKS-1:0] wr_hit;
    logic [NUM_DISKS-1:0] ram_claim;
    logic [NUM_DISKS-1:0] stack_claim;
    logic [NUM_DISKS-1:0] claim_any;
    logic [3:0]           n_claims;
    logic                 win_found;
    logic [3:0]           win_idx;
    logic [1:0]           win_page;
    logic [5:0]           page_sum;
    logic [2:0]           top;
    logic                 access;
    logic                 commit;
    logic [7:0]           cnt_r;
    logic                 unused_addr;

    assign top         = address[15:13];
    assign access      = memrd | memwr;
    assign commit      = clke & m1;
    assign pending     = pending_r;
    assign conflict_cnt = cnt_r;
    // Low address bits never take part in window decoding.
    assign unused_addr = ^address[12:0];

    // Port decode: one strobe per disk, ports beyond the last disk match nothing.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NUM_DISKS; i++)
            wr_hit[i] = clke & port_wr & (port_addr == PORT_BASE + 8'(i));
    end

    // Shadow/committed register update; a write in the same edge as a commit
    // refreshes the shadow and keeps that disk pending for the next fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_DISKS; i++) begin
                shadow[i]    <= 8'h00;
                committed[i] <= 8'h00;
            end
            pending_r <= '0;
        end else begin
            for (int i = 0; i < NUM_DISKS; i++) begin
                if (wr_hit[i]) begin
                    shadow[i] <= data_in;
                    if (DEFER)
                        pending_r[i] <= 1'b1;
                    else
                        committed[i] <= data_in;
                end else if (DEFER && commit && pending_r[i]) begin
                    committed[i] <= shadow[i];
                    pending_r[i] <= 1'b0;
                end
            end
        end
    end

    // Per-disk claims from the committed registers.
    always_comb begin
        ram_claim   = '0;
        stack_claim = '0;
        for (int i = 0; i < NUM_DISKS; i++) begin
            ram_claim[i] = committed[i][5] &
                           ((top == 3'b101) | (top == 3'b110) |
                            ((top == 3'b100) & committed[i][6]) |
                            ((top == 3'b111) & committed[i][7]));
            stack_claim[i] = committed[i][4] & stack;
        end
        claim_any = ram_claim | stack_claim;
    end

    // Winner selection: stack claims beat ram claims, lowest index wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 4'd0;
        win_page  = 2'd0;
        if (|stack_claim) begin
            for (int i = NUM_DISKS - 1; i >= 0; i--) begin
                if (stack_claim[i]) begin
                    win_found = 1'b1;
                    win_idx   = 4'(i);
                    win_page  = committed[i][3:2];
                end
            end
        end else begin
            for (int i = NUM_DISKS - 1; i >= 0; i--) begin
                if (ram_claim[i]) begin
                    win_found = 1'b1;
                    win_idx   = 4'(i);
                    win_page  = committed[i][1:0];
                end
            end
        end
    end

    // SDRAM page output: page 0 is main RAM, disk d owns pages 1+4d .. 4+4d.
    always_comb begin
        page_sum    = 6'd1 + {win_idx, 2'b00} + {4'd0, win_page};
        bigram_addr = '0;
        blk_n       = 1'b1;
        if (access && win_found) begin
            bigram_addr = BA_W'(page_sum);
            blk_n       = 1'b0;
        end
    end

    // Count of disks claiming the current access.
    always_comb begin
        n_claims = 4'd0;
        for (int i = 0; i < NUM_DISKS; i++)
            n_claims = n_claims + 4'(claim_any[i]);
    end

    // Saturating conflict counter for accesses claimed by more than one disk.
    always_ff @(posedge clk) begin
        if (reset)
            cnt_r <= 8'd0;
        else if (clke && access && (n_claims >= 4'd2) && (cnt_r != 8'hFF))
            cnt_r <= cnt_r + 8'd1;
    end

endmodule
